acc_proc_core: RTL and testbench

// - Parametrised accumulator mini-processor: DATA_W-bit ACC/EXT datapath, 16-entry register file, IMEM_DEPTH x 8b program RAM.
// - A host loads program/registers, pulses start, and the core runs until HALT.
// - Adds host load, start/halt handshake, a register-indirect jump range and an iterative multi-cycle divider.

---
 rtl/acc_proc_core.sv | 183 ++++++++++++++++++
 tb/tb_acc_proc_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_proc_core.sv
// Accumulator mini-processor: ACC/EXT datapath, 16-entry register file, host-loaded program RAM.
// Define ACC_PROC_DIV_EN to make op 4 an iterative restoring divider; otherwise op 4 is a NOP.
`timescale 1ns/1ps
module acc_proc_core #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMEM_DEPTH = 16,
    localparam int unsigned PC_W      = $clog2(IMEM_DEPTH)
) (
    input  logic              slow_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              host_we,
    input  logic              host_sel,
    input  logic [7:0]        host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] ext,
    output logic              carry,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted
);
    typedef enum logic [1:0] {StIdle, StExec, StDiv, StHalt} state_e;

    localparam logic [3:0] OpMisc = 4'h0, OpAdd = 4'h1, OpSub = 4'h2, OpMul = 4'h3;
    localparam logic [3:0] OpDiv  = 4'h4, OpAnd = 4'h5, OpXor = 4'h6, OpCmpx = 4'h7;
    localparam logic [3:0] OpJc   = 4'h8, OpLda = 4'h9, OpSta = 4'hA, OpJmp = 4'hB;
    localparam logic [3:0] OpHalt = 4'hF;

    state_e            state;
    logic [7:0]        imem [IMEM_DEPTH];
    logic [DATA_W-1:0] rf [16];

    logic [7:0]          instr;
    logic [3:0]          op, n;
    logic [DATA_W-1:0]   d_val, acc_nx, ext_nx;
    logic                carry_nx;
    logic [PC_W-1:0]     pc_nx;
    logic [DATA_W:0]     sum_res, diff_res, inc_res, dec_res;
    logic [2*DATA_W-1:0] prod;
    logic                host_ok;
    logic                unused_host_addr;

    assign host_ok          = host_we && !busy;
    assign unused_host_addr = ^host_addr;

    assign instr    = imem[pc];
    assign op       = instr[7:4];
    assign n        = instr[3:0];
    assign d_val    = rf[n];
    assign dbg_data = rf[dbg_addr];

    // Widened by one bit so the MSB is the carry (ADD/INC) or borrow (SUB/DEC).
    assign sum_res  = {1'b0, acc} + {1'b0, d_val};
    assign diff_res = {1'b0, acc} - {1'b0, d_val};
    assign inc_res  = {1'b0, acc} + {{DATA_W{1'b0}}, 1'b1};
    assign dec_res  = {1'b0, acc} - {{DATA_W{1'b0}}, 1'b1};
    assign prod     = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, d_val};

    always_comb begin
        acc_nx   = acc;
        ext_nx   = ext;
        carry_nx = carry;
        pc_nx    = pc + PC_W'(1);
        case (op)
            OpMisc: begin
                case (n)
                    4'h1: acc_nx = {acc[DATA_W-2:0], 1'b0};
                    4'h2: acc_nx = {1'b0, acc[DATA_W-1:1]};
                    4'h3: acc_nx = {acc[0], acc[DATA_W-1:1]};
                    4'h4: acc_nx = {acc[DATA_W-2:0], acc[DATA_W-1]};
                    4'h5: acc_nx = {acc[DATA_W-1], acc[DATA_W-1:1]};
                    4'h6: {carry_nx, acc_nx} = inc_res;
                    4'h7: {carry_nx, acc_nx} = dec_res;
                    default: ;
                endcase
            end
            OpAdd:  {carry_nx, acc_nx} = sum_res;
            OpSub:  {carry_nx, acc_nx} = diff_res;
            OpMul:  {ext_nx, acc_nx} = prod;
`ifdef ACC_PROC_DIV_EN
            OpDiv:  pc_nx = pc;
`endif
            OpAnd:  acc_nx = acc & d_val;
            OpXor:  acc_nx = acc ^ d_val;
            OpCmpx: acc_nx = (acc == d_val) ? '0 : (acc & d_val);
            OpJc:   if (carry) pc_nx = d_val[PC_W-1:0];
            OpLda:  acc_nx = d_val;
            OpJmp:  pc_nx = d_val[PC_W-1:0];
            OpHalt: pc_nx = pc;
            default: ;
        endcase
    end

`ifdef ACC_PROC_DIV_EN
    localparam int unsigned CNT_W = $clog2(DATA_W);
    logic [DATA_W-1:0] div_q, div_r, div_d, rem_nx, q_nx;
    logic [CNT_W-1:0]  div_cnt;
    logic [DATA_W:0]   rem_sh, rem_sub;
    logic              rem_ge, unused_borrow;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_sh        = {div_r, div_q[DATA_W-1]};
    assign rem_sub       = rem_sh - {1'b0, div_d};
    assign rem_ge        = rem_sh >= {1'b0, div_d};
    assign rem_nx        = rem_ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    assign q_nx          = {div_q[DATA_W-2:0], rem_ge};
    assign unused_borrow = rem_sub[DATA_W];
`endif

    // Program RAM survives reset.
    always_ff @(posedge slow_clk) begin
        if (host_ok && !host_sel) imem[host_addr[PC_W-1:0]] <= host_wdata[7:0];
    end

    always_ff @(posedge slow_clk) begin
        if (!rst_n) begin
            state  <= StIdle;
            acc    <= '0;
            ext    <= '0;
            carry  <= 1'b0;
            pc     <= '0;
            busy   <= 1'b0;
            halted <= 1'b0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
`ifdef ACC_PROC_DIV_EN
            div_q   <= '0;
            div_r   <= '0;
            div_d   <= '0;
            div_cnt <= '0;
`endif
        end else begin
            if (host_ok && host_sel) rf[host_addr[3:0]] <= host_wdata;
            case (state)
                StIdle, StHalt: begin
                    if (start) begin
                        state  <= StExec;
                        pc     <= '0;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                StExec: begin
                    acc   <= acc_nx;
                    ext   <= ext_nx;
                    carry <= carry_nx;
                    pc    <= pc_nx;
                    if (op == OpSta) rf[n] <= acc;
                    if (op == OpHalt) begin
                        state  <= StHalt;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end
`ifdef ACC_PROC_DIV_EN
                    if (op == OpDiv) begin
                        state   <= StDiv;
                        div_q   <= acc;
                        div_d   <= d_val;
                        div_r   <= '0;
                        div_cnt <= '0;
                    end
`endif
                end
`ifdef ACC_PROC_DIV_EN
                StDiv: begin
                    div_q   <= q_nx;
                    div_r   <= rem_nx;
                    div_cnt <= div_cnt + CNT_W'(1);
                    if (div_cnt == CNT_W'(DATA_W - 1)) begin
                        acc   <= q_nx;
                        ext   <= rem_nx;
                        pc    <= pc + PC_W'(1);
                        state <= StExec;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_proc_core.sv
// Directed-vector bench for acc_proc_core (DATA_W=8, IMEM_DEPTH=16); follows ACC_PROC_DIV_EN.
`timescale 1ns/1ps
module tb_acc_proc_core;
    logic       slow_clk = 1'b0;
    logic       rst_n, start, host_we, host_sel;
    logic [7:0] host_addr, host_wdata, dbg_data, acc, ext;
    logic [3:0] dbg_addr, pc;
    logic       carry, busy, halted;

`ifdef ACC_PROC_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cycles;
    logic [7:0] prog [$];

    acc_proc_core #(.DATA_W(8), .IMEM_DEPTH(16)) dut (
        .slow_clk  (slow_clk),
        .rst_n     (rst_n),
        .start     (start),
        .host_we   (host_we),
        .host_sel  (host_sel),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .acc       (acc),
        .ext       (ext),
        .carry     (carry),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 slow_clk = ~slow_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic host_write(input logic sel, input logic [7:0] addr, input logic [7:0] data);
        host_we    = 1'b1;
        host_sel   = sel;
        host_addr  = addr;
        host_wdata = data;
        tick();
        host_we = 1'b0;
    endtask

    task automatic load_prog();
        foreach (prog[i]) host_write(1'b0, 8'(i), prog[i]);
    endtask

    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        while (busy && busy_cycles < 200) begin
            busy_cycles++;
            tick();
        end
        check("halt_reached", 32'(halted), 1);
    endtask

    task automatic run_prog(output int busy_cycles);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(busy_cycles);
    endtask

    task automatic check_reg(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        check(tag, 32'(dbg_data), exp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; host_we = 1'b0; host_sel = 1'b0;
        host_addr = '0; host_wdata = '0; dbg_addr = '0;
        do_reset();
        check("rst_acc", 32'(acc), 0);
        check("rst_ext", 32'(ext), 0);
        check("rst_carry", 32'(carry), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);

        // DIV 10/3
        host_write(1'b1, 8'd1, 8'd10);
        host_write(1'b1, 8'd2, 8'd3);
        prog = '{8'h91, 8'h42, 8'hF0};
        load_prog();
        run_prog(cycles);
        check("div_busy_cycles", 32'(cycles), DivEn ? 11 : 3);
        check("div_acc", 32'(acc), DivEn ? 3 : 10);
        check("div_ext", 32'(ext), DivEn ? 1 : 0);
        check("div_pc", 32'(pc), 2);

        // ADD overflow, then SUB with borrow
        do_reset();
        host_write(1'b1, 8'd1, 8'd200);
        host_write(1'b1, 8'd2, 8'd100);
        prog = '{8'h91, 8'h12, 8'hF0};
        load_prog();
        run_prog(cycles);
        check("add_acc", 32'(acc), 44);
        check("add_carry", 32'(carry), 1);
        prog = '{8'h92, 8'h21, 8'hF0};
        load_prog();
        run_prog(cycles);
        check("sub_acc", 32'(acc), 156);
        check("sub_carry", 32'(carry), 1);

        // MUL 20*13 = 260
        do_reset();
        host_write(1'b1, 8'd1, 8'd20);
        host_write(1'b1, 8'd2, 8'd13);
        prog = '{8'h91, 8'h32, 8'hF0};
        load_prog();
        run_prog(cycles);
        check("mul_ext", 32'(ext), 1);
        check("mul_acc", 32'(acc), 4);

        // INC wraps to 0 with carry, JC taken
        do_reset();
        host_write(1'b1, 8'd1, 8'd255);
        host_write(1'b1, 8'd3, 8'd5);
        prog = '{8'h91, 8'h06, 8'h83, 8'hF0, 8'hF0, 8'h90, 8'hF0};
        load_prog();
        run_prog(cycles);
        check("jc_pc", 32'(pc), 6);
        check("jc_acc", 32'(acc), 0);
        check("jc_carry", 32'(carry), 1);

        // Shifts/rotates on 0x96, each stored with STA
        do_reset();
        host_write(1'b1, 8'd1, 8'h96);
        prog = '{8'h91, 8'h01, 8'hA5, 8'h91, 8'h05, 8'hA6, 8'h91, 8'h03,
                 8'hA7, 8'h91, 8'h04, 8'hA8, 8'h91, 8'h02, 8'hA9, 8'hF0};
        load_prog();
        run_prog(cycles);
        check_reg("shl", 4'd5, 32'h2C);
        check_reg("asr", 4'd6, 32'hCB);
        check_reg("ror", 4'd7, 32'h4B);
        check_reg("rol", 4'd8, 32'h2D);
        check_reg("shr", 4'd9, 32'h4B);
        check("shift_carry", 32'(carry), 0);

        // AND/XOR/CMPX/DEC
        do_reset();
        host_write(1'b1, 8'd1, 8'hF0);
        host_write(1'b1, 8'd2, 8'h3C);
        host_write(1'b1, 8'd3, 8'hF0);
        prog = '{8'h91, 8'h52, 8'hAA, 8'h91, 8'h62, 8'hAB, 8'h91, 8'h73,
                 8'hAC, 8'h91, 8'h72, 8'h07, 8'hAD, 8'h90, 8'h07, 8'hF0};
        load_prog();
        run_prog(cycles);
        check_reg("and", 4'd10, 32'h30);
        check_reg("xor", 4'd11, 32'hCC);
        check_reg("cmpx_eq", 4'd12, 32'h00);
        check_reg("cmpx_ne_dec", 4'd13, 32'h2F);
        check("dec_wrap_acc", 32'(acc), 32'hFF);
        check("dec_borrow", 32'(carry), 1);

        // DIV by zero; a host write while busy must be dropped
        do_reset();
        host_write(1'b1, 8'd1, 8'd10);
        prog = '{8'h91, 8'h40, 8'hF0};
        load_prog();
        start = 1'b1;
        tick();
        start = 1'b0;
        host_write(1'b1, 8'd15, 8'h77);
        wait_done(cycles);
        check("div0_acc", 32'(acc), DivEn ? 255 : 10);
        check("div0_ext", 32'(ext), DivEn ? 10 : 0);
        check_reg("busy_write_ignored", 4'd15, 0);

        // Reset in the middle of the divide
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_acc", 32'(acc), 0);
        check("midrst_ext", 32'(ext), 0);
        check("midrst_pc", 32'(pc), 0);
        check("midrst_busy", 32'(busy), 0);
        check_reg("midrst_r1", 4'd1, 0);

        // Program RAM kept across reset
        host_write(1'b1, 8'd1, 8'd10);
        run_prog(cycles);
        check("imem_kept_acc", 32'(acc), DivEn ? 255 : 10);
        check("imem_kept_pc", 32'(pc), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
